// File: rtl/commutation_monitor.sv
// Gate-drive commutation monitor: classifies the registered gate word, tracks dwell and
// commutation time, reports the connected phase and latches the first protection fault.
module commutation_monitor #(
  parameter int unsigned TDON_MIN  = 2,
  parameter int unsigned TDOFF_MIN = 10,
  parameter int unsigned TCOMM_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  gates,
  input  logic        fault_clr,
  output logic [1:0]  load_phase,
  output logic        phase_valid,
  output logic        commutating,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [15:0] comm_count
);

  localparam int unsigned GW = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned TW = $clog2(TCOMM_MAX + 2);

  localparam logic [DW-1:0] DWELL_MAX = '1;
  localparam logic [DW-1:0] DON_MIN   = DW'(TDON_MIN);
  localparam logic [DW-1:0] DOFF_MIN  = DW'(TDOFF_MIN);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TCOMM_MAX);

  localparam logic [2:0] F_ILLEGAL  = 3'b001;
  localparam logic [2:0] F_MULTI    = 3'b010;
  localparam logic [2:0] F_DON      = 3'b011;
  localparam logic [2:0] F_DOFF     = 3'b100;
  localparam logic [2:0] F_OPEN     = 3'b101;
  localparam logic [2:0] F_TIMEOUT  = 3'b110;

  typedef enum logic [2:0] {
    CLS_ZERO, CLS_SINGLE, CLS_FULL, CLS_OVERLAP, CLS_ILLEGAL
  } pat_cls_t;

  function automatic pat_cls_t classify(input logic [GW-1:0] g);
    pat_cls_t c;
    case (g)
      6'b000000:                   c = CLS_ZERO;
      6'b110000, 6'b001100,
      6'b000011:                   c = CLS_FULL;
      6'b101000, 6'b100010, 6'b001010,
      6'b010100, 6'b010001, 6'b000101: c = CLS_OVERLAP;
      default:                     c = $onehot(g) ? CLS_SINGLE : CLS_ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] phase_of(input logic [GW-1:0] g);
    logic [1:0] p;
    case (g)
      6'b110000: p = 2'b01;
      6'b001100: p = 2'b10;
      6'b000011: p = 2'b11;
      default:   p = 2'b00;
    endcase
    return p;
  endfunction

  logic [GW-1:0] g_q;
  logic [GW-1:0] g_prev;
  logic [DW-1:0] dwell;
  logic [TW-1:0] timer;
  logic          armed;

  pat_cls_t   cls_cur_c;
  pat_cls_t   cls_prev_c;
  logic       changed_c;
  logic       multi_c;
  logic       comm_c;
  logic       hit_c;
  logic [2:0] code_c;
  logic [1:0] phase_c;

  // Fault detection with fixed priority; dwell holds the outgoing pattern's length on a change.
  always_comb begin
    cls_cur_c  = classify(g_q);
    cls_prev_c = classify(g_prev);
    phase_c    = phase_of(g_q);
    changed_c  = (g_q != g_prev);
    multi_c    = !$onehot0(g_q ^ g_prev);
    comm_c     = armed && (cls_cur_c != CLS_FULL);
    hit_c      = 1'b1;
    code_c     = 3'b000;
    if (cls_cur_c == CLS_ILLEGAL) begin
      code_c = F_ILLEGAL;
    end else if (armed && (cls_cur_c == CLS_ZERO)) begin
      code_c = F_OPEN;
    end else if (armed && multi_c) begin
      code_c = F_MULTI;
    end else if (changed_c && (cls_prev_c == CLS_OVERLAP) && (dwell < DON_MIN)) begin
      code_c = F_DON;
    end else if (changed_c && (cls_prev_c == CLS_SINGLE) && (dwell < DOFF_MIN)) begin
      code_c = F_DOFF;
    end else if (comm_c && (timer >= TIMER_MAX)) begin
      code_c = F_TIMEOUT;
    end else begin
      hit_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q         <= '0;
      g_prev      <= '0;
      dwell       <= '0;
      timer       <= '0;
      armed       <= 1'b0;
      load_phase  <= 2'b00;
      phase_valid <= 1'b0;
      commutating <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 3'b000;
      comm_count  <= '0;
    end else begin
      g_q    <= gates;
      g_prev <= g_q;

      if (changed_c) begin
        dwell <= DW'(1);
      end else if (dwell != DWELL_MAX) begin
        dwell <= dwell + DW'(1);
      end

      if (g_q != '0) begin
        armed <= 1'b1;
      end

      // Counts consecutive commutating cycles before the current one.
      if (!comm_c) begin
        timer <= '0;
      end else if (timer != TIMER_MAX) begin
        timer <= timer + TW'(1);
      end

      phase_valid <= (cls_cur_c == CLS_FULL);
      commutating <= comm_c;
      if (cls_cur_c == CLS_FULL) begin
        load_phase <= phase_c;
        if ((load_phase != 2'b00) && (phase_c != load_phase)) begin
          comm_count <= comm_count + CW'(1);
        end
      end

      // A fault present in the clear cycle re-latches rather than being lost.
      if (hit_c && (!fault || fault_clr)) begin
        fault      <= 1'b1;
        fault_code <= code_c;
      end else if (fault_clr) begin
        fault      <= 1'b0;
        fault_code <= 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_commutation_monitor.sv
// Scoreboarded bench for commutation_monitor: directed sequences plus a randomized gate walk,
// checked every cycle against a history-based reference model.
module tb_commutation_monitor;

  localparam int unsigned TDON  = 2;
  localparam int unsigned TDOFF = 10;
  localparam int unsigned TCOMM = 64;

  typedef struct packed {
    logic [1:0]  lp;
    logic        pv;
    logic        cm;
    logic        f;
    logic [2:0]  fc;
    logic [15:0] cc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [5:0]  gates;
  logic        fault_clr;
  logic [1:0]  load_phase;
  logic        phase_valid;
  logic        commutating;
  logic        fault;
  logic [2:0]  fault_code;
  logic [15:0] comm_count;

  commutation_monitor #(
    .TDON_MIN (TDON),
    .TDOFF_MIN(TDOFF),
    .TCOMM_MAX(TCOMM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gates      (gates),
    .fault_clr  (fault_clr),
    .load_phase (load_phase),
    .phase_valid(phase_valid),
    .commutating(commutating),
    .fault      (fault),
    .fault_code (fault_code),
    .comm_count (comm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [5:0]  hist[$];     // registered gate word, one entry per cycle since reset
  int          fnz;         // index of first nonzero entry in hist, -1 if none
  logic        m_fault;
  logic [2:0]  m_code;
  logic [15:0] m_count;
  logic [1:0]  m_lastph;
  int          errors;
  int          checks;
  int          cyc;

  // Pattern class from per-leg view: 0 zero, 1 single, 2 full, 3 overlap, 4 illegal.
  function automatic int cls_of(input logic [5:0] g);
    logic [2:0] pos;
    logic [2:0] neg;
    int         n;
    pos = {g[5], g[3], g[1]};
    neg = {g[4], g[2], g[0]};
    n   = $countones(g);
    if (n == 0) return 0;
    if (n == 1) return 1;
    if (n == 2 && pos == neg) return 2;
    if (n == 2 && (pos == 3'b000 || neg == 3'b000)) return 3;
    return 4;
  endfunction

  function automatic logic [1:0] phase_of(input logic [5:0] g);
    if (g[5]) return 2'd1;
    if (g[3]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic void model_reset();
    hist.delete();
    hist.push_back(6'd0);
    fnz      = -1;
    m_fault  = 1'b0;
    m_code   = 3'd0;
    m_count  = 16'd0;
    m_lastph = 2'd0;
  endfunction

  // Expected outputs after the coming edge, from the gate history seen so far.
  function automatic exp_t model_eval(input bit clr);
    exp_t       e;
    int         n;
    int         run;
    int         crun;
    int         code;
    logic [5:0] cur;
    logic [5:0] prev;
    bit         armed;
    n     = hist.size();
    cur   = hist[n-1];
    prev  = (n > 1) ? hist[n-2] : 6'd0;
    armed = (fnz >= 0) && (fnz < n - 1);
    run   = 0;
    for (int j = n - 2; j >= 0 && hist[j] == prev && run < 255; j--) run++;
    crun = 0;
    for (int j = n - 1; fnz >= 0 && j > fnz && cls_of(hist[j]) != 2 && crun <= int'(TCOMM); j--)
      crun++;
    code = 0;
    if (cls_of(cur) == 4) code = 1;
    else if (armed && cur == 6'd0) code = 5;
    else if (armed && $countones(cur ^ prev) > 1) code = 2;
    else if (cur != prev && cls_of(prev) == 3 && run < int'(TDON)) code = 3;
    else if (cur != prev && cls_of(prev) == 1 && run < int'(TDOFF)) code = 4;
    else if (crun > int'(TCOMM)) code = 6;
    if (code != 0 && (!m_fault || clr)) begin
      m_fault = 1'b1;
      m_code  = 3'(code);
    end else if (clr) begin
      m_fault = 1'b0;
      m_code  = 3'd0;
    end
    if (cls_of(cur) == 2) begin
      if (m_lastph != 2'd0 && phase_of(cur) != m_lastph) m_count = m_count + 16'd1;
      m_lastph = phase_of(cur);
    end
    e.lp = m_lastph;
    e.pv = (cls_of(cur) == 2);
    e.cm = armed && (cls_of(cur) != 2);
    e.f  = m_fault;
    e.fc = m_code;
    e.cc = m_count;
    return e;
  endfunction

  task automatic step(input logic [5:0] g, input bit clr, input bit r);
    exp_t e;
    @(negedge clk);
    gates     = g;
    fault_clr = clr;
    rst       = r;
    if (r) begin
      model_reset();
      e = '0;
    end else begin
      e = model_eval(clr);
      hist.push_back(g);
      if (fnz < 0 && g != 6'd0) fnz = hist.size() - 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [5:0] g, input int n);
    for (int i = 0; i < n; i++) step(g, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(6'd0, 1'b0, 1'b1);
    step(6'd0, 1'b0, 1'b1);
  endtask

  // Scoreboard monitor: one comparison per clock once expectations exist.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = '{load_phase, phase_valid, commutating, fault, fault_code, comm_count};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL outputs check %0d: got lp=%b pv=%b cm=%b f=%b fc=%b cc=%0d, want lp=%b pv=%b cm=%b f=%b fc=%b cc=%0d",
                   checks, act.lp, act.pv, act.cm, act.f, act.fc, act.cc,
                   e.lp, e.pv, e.cm, e.f, e.fc, e.cc);
        end
      end
    end
  end

  initial begin
    logic [5:0] legal [16];
    logic [5:0] g;
    int         len;
    int         r;
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    gates     = 6'd0;
    fault_clr = 1'b0;
    model_reset();
    legal = '{6'b000000, 6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010,
              6'b000001, 6'b110000, 6'b001100, 6'b000011, 6'b101000, 6'b100010,
              6'b001010, 6'b010100, 6'b010001, 6'b000101};

    // Phase A held after reset, then a clean A-to-B commutation.
    do_reset();
    hold(6'b110000, 20);
    hold(6'b100000, 10);
    hold(6'b101000, 2);
    hold(6'b001000, 10);
    hold(6'b001100, 5);

    // Short overlap dwell.
    do_reset();
    hold(6'b110000, 3);
    hold(6'b100000, 10);
    hold(6'b101000, 1);
    hold(6'b001000, 10);
    hold(6'b001100, 3);

    // Illegal word, later faults frozen, then a clear on a quiet full phase.
    do_reset();
    hold(6'b110000, 3);
    hold(6'b100100, 1);
    hold(6'b000000, 1);
    hold(6'b110000, 4);
    step(6'b110000, 1'b1, 1'b0);
    hold(6'b110000, 3);

    // Open load, clear while the condition persists, then zero under reset.
    do_reset();
    hold(6'b001100, 3);
    hold(6'b000000, 2);
    step(6'b000000, 1'b1, 1'b0);
    hold(6'b000000, 2);
    do_reset();
    hold(6'b001100, 3);
    step(6'b000000, 1'b0, 1'b1);
    step(6'b000000, 1'b0, 1'b1);
    hold(6'b000000, 2);

    // Commutation timeout, then reset in the middle of a long hold (with clear also asserted).
    do_reset();
    hold(6'b110000, 3);
    hold(6'b100000, 70);
    do_reset();
    hold(6'b110000, 3);
    hold(6'b100000, 30);
    step(6'b100000, 1'b1, 1'b1);
    hold(6'b100000, 3);

    // Randomized gate walk: mostly single-bit steps, some legal jumps, a few arbitrary words.
    do_reset();
    g = 6'b110000;
    repeat (300) begin
      r = int'($urandom_range(99));
      if (r < 65)      g = g ^ (6'd1 << $urandom_range(5));
      else if (r < 95) g = legal[$urandom_range(15)];
      else             g = 6'($urandom);
      len = ($urandom_range(19) == 0) ? 70 : int'($urandom_range(12, 1));
      for (int i = 0; i < len; i++)
        step(g, ($urandom_range(24) == 0), ($urandom_range(399) == 0));
    end

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      @(posedge clk);
      cyc++;
    end
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
